// File: rtl/sbox_sched_pkg.sv
// sbox_sched_pkg: shared definitions for the S-box bank scheduler.
//   - FSM state encodings (ST_IDLE, ST_DATA)
//   - issue tag type constants (TAG_KEY, TAG_DATA)
//   - bank mode constant MODE_ENC (1 = forward S-box)
package sbox_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  localparam logic TAG_KEY  = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  localparam logic MODE_ENC = 1'b1;

endpackage : sbox_sched_pkg

// File: rtl/sbox_sched.sv
// sbox_sched: shares one registered S-box bank (SBOX_NUM byte lanes, one
// cycle latency) between key expansion (one word per request) and the round
// datapath (DATA_WORDS words per job). Every bank issue carries a tag that
// follows the bank latency so the returning word is steered to its owner.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   key_req/key_word         key-expansion request, word to substitute
//   key_gnt                  combinational: key_word issued this cycle
//   key_rsp_valid/key_rsp    registered response pulse / forward S-box word
//   data_req/data_enc_dec    datapath job request and mode (1 = encrypt)
//   data_state               job input, word i = bits [W*i +: W]
//   data_gnt                 combinational: job accepted this cycle
//   data_done/data_out       registered completion pulse / job result
//   sbox_in/enc_dec          issue word and mode towards the bank
//   sbox_out_enc/_dec        bank outputs, one cycle after issue
//
// Build option: define SBOX_SCHED_KEY_PREEMPT_EN to let a key request steal
// the issue slot while a datapath job is running (the job pauses one cycle
// per stolen slot). Without it a key request waits until the FSM is idle.
module sbox_sched
  import sbox_sched_pkg::*;
#(
  parameter int SBOX_NUM   = 4,
  parameter int DATA_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_req,
  input  logic [8*SBOX_NUM-1:0]            key_word,
  output logic                           key_gnt,
  output logic                           key_rsp_valid,
  output logic [8*SBOX_NUM-1:0]            key_rsp,
  input  logic                           data_req,
  input  logic                           data_enc_dec,
  input  logic [8*SBOX_NUM*DATA_WORDS-1:0] data_state,
  output logic                           data_gnt,
  output logic                           data_done,
  output logic [8*SBOX_NUM*DATA_WORDS-1:0] data_out,
  output logic [8*SBOX_NUM-1:0]            sbox_in,
  output logic                           enc_dec,
  input  logic [8*SBOX_NUM-1:0]            sbox_out_enc,
  input  logic [8*SBOX_NUM-1:0]            sbox_out_dec
);

  localparam int W     = 8 * SBOX_NUM;
  localparam int S     = W * DATA_WORDS;
  localparam int CNT_W = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WORDS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [S-1:0]       buf_q, buf_d;
  logic               mode_q, mode_d;
  logic               tag_valid_q, tag_valid_d;
  logic               tag_type_q, tag_type_d;
  logic [CNT_W-1:0]   tag_idx_q, tag_idx_d;
  logic [W-1:0]       key_rsp_q, key_rsp_d;
  logic               key_rsp_valid_q, key_rsp_valid_d;
  logic [S-1:0]       data_out_q, data_out_d;
  logic               data_done_q, data_done_d;

  logic               key_gnt_s;
  logic               data_gnt_s;
  logic [W-1:0]       sbox_in_s;
  logic               enc_dec_s;
  logic               steal_s;
  logic [W-1:0]       cur_word_s;

  assign cur_word_s = buf_q[W*int'(cnt_q) +: W];

  // Issue arbitration, FSM next state and tag generation for the issue slot.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    mode_d      = mode_q;
    key_gnt_s   = 1'b0;
    data_gnt_s  = 1'b0;
    sbox_in_s   = '0;
    enc_dec_s   = MODE_ENC;
    tag_valid_d = 1'b0;
    tag_type_d  = TAG_KEY;
    tag_idx_d   = '0;
    steal_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_req) begin
          key_gnt_s   = 1'b1;
          sbox_in_s   = key_word;
          tag_valid_d = 1'b1;
          tag_type_d  = TAG_KEY;
        end else if (data_req) begin
          data_gnt_s = 1'b1;
          buf_d      = data_state;
          mode_d     = data_enc_dec;
          cnt_d      = '0;
          state_d    = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
`ifdef SBOX_SCHED_KEY_PREEMPT_EN
        steal_s = key_req;
`else
        steal_s = 1'b0;
`endif
        if (steal_s) begin
          // Key takes this slot; the job counter holds and resumes next cycle.
          key_gnt_s   = 1'b1;
          sbox_in_s   = key_word;
          tag_valid_d = 1'b1;
          tag_type_d  = TAG_KEY;
        end else begin
          sbox_in_s   = cur_word_s;
          enc_dec_s   = mode_q;
          tag_valid_d = 1'b1;
          tag_type_d  = TAG_DATA;
          tag_idx_d   = cnt_q;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture the bank output one cycle after issue, steered by the tag.
  always_comb begin
    key_rsp_d       = key_rsp_q;
    key_rsp_valid_d = 1'b0;
    data_out_d      = data_out_q;
    data_done_d     = 1'b0;

    if (tag_valid_q) begin
      if (tag_type_q == TAG_KEY) begin
        key_rsp_d       = sbox_out_enc;
        key_rsp_valid_d = 1'b1;
      end else begin
        // mode_q still belongs to this job: a new job can only latch on the
        // same edge as the final capture, and the flop update is not yet seen.
        data_out_d[W*int'(tag_idx_q) +: W] = (mode_q == MODE_ENC) ? sbox_out_enc
                                                                  : sbox_out_dec;
        data_done_d = (tag_idx_q == LAST_IDX);
      end
    end else begin
      key_rsp_valid_d = 1'b0;
    end
  end

  // State, job buffer, tag pipeline and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      buf_q           <= '0;
      mode_q          <= 1'b0;
      tag_valid_q     <= 1'b0;
      tag_type_q      <= TAG_KEY;
      tag_idx_q       <= '0;
      key_rsp_q       <= '0;
      key_rsp_valid_q <= 1'b0;
      data_out_q      <= '0;
      data_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      buf_q           <= buf_d;
      mode_q          <= mode_d;
      tag_valid_q     <= tag_valid_d;
      tag_type_q      <= tag_type_d;
      tag_idx_q       <= tag_idx_d;
      key_rsp_q       <= key_rsp_d;
      key_rsp_valid_q <= key_rsp_valid_d;
      data_out_q      <= data_out_d;
      data_done_q     <= data_done_d;
    end
  end

  assign key_gnt       = key_gnt_s;
  assign data_gnt      = data_gnt_s;
  assign sbox_in       = sbox_in_s;
  assign enc_dec       = enc_dec_s;
  assign key_rsp       = key_rsp_q;
  assign key_rsp_valid = key_rsp_valid_q;
  assign data_out      = data_out_q;
  assign data_done     = data_done_q;

endmodule : sbox_sched

// File: tb/tb_sbox_sched.sv
// tb_sbox_sched: directed bench for sbox_sched with a behavioural AES S-box
// bank (forward and inverse, one cycle latency) attached to the bank ports.
module tb_sbox_sched;

  localparam int SBOX_NUM   = 4;
  localparam int DATA_WORDS = 4;
  localparam int W          = 8 * SBOX_NUM;
  localparam int S          = W * DATA_WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_req;
  logic [W-1:0] key_word;
  logic         key_gnt;
  logic         key_rsp_valid;
  logic [W-1:0] key_rsp;
  logic         data_req;
  logic         data_enc_dec;
  logic [S-1:0] data_state;
  logic         data_gnt;
  logic         data_done;
  logic [S-1:0] data_out;
  logic [W-1:0] sbox_in;
  logic         enc_dec;
  logic [W-1:0] sbox_out_enc = '0;
  logic [W-1:0] sbox_out_dec = '0;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  sbox_sched #(.SBOX_NUM(SBOX_NUM), .DATA_WORDS(DATA_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_req      (key_req),
    .key_word     (key_word),
    .key_gnt      (key_gnt),
    .key_rsp_valid(key_rsp_valid),
    .key_rsp      (key_rsp),
    .data_req     (data_req),
    .data_enc_dec (data_enc_dec),
    .data_state   (data_state),
    .data_gnt     (data_gnt),
    .data_done    (data_done),
    .data_out     (data_out),
    .sbox_in      (sbox_in),
    .enc_dec      (enc_dec),
    .sbox_out_enc (sbox_out_enc),
    .sbox_out_dec (sbox_out_dec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES S-box reference (GF(2^8) inverse + affine) ---------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 1; i < 256; i++) begin
      if (gmul(a, 8'(i)) == 8'h01) r = 8'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] fwd(input logic [7:0] b);
    logic [7:0] v;
    v = ginv(b);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [W-1:0] fwd_w(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int b = 0; b < SBOX_NUM; b++) r[8*b +: 8] = fwd(w[8*b +: 8]);
    return r;
  endfunction

  function automatic logic [W-1:0] inv_w(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int b = 0; b < SBOX_NUM; b++) r[8*b +: 8] = inv(w[8*b +: 8]);
    return r;
  endfunction

  // Registered bank model.
  always @(posedge clk) begin
    sbox_out_enc <= fwd_w(sbox_in);
    sbox_out_dec <= inv_w(sbox_in);
  end

  // ---------------- event monitor ------------------------------------------
  int           key_cyc_q[$];
  logic [W-1:0] key_val_q[$];
  int           done_cyc_q[$];
  logic [S-1:0] done_val_q[$];
  int           dec_cnt = 0;

  always @(negedge clk) begin
    #1;
    if (key_rsp_valid) begin
      key_cyc_q.push_back(cyc);
      key_val_q.push_back(key_rsp);
    end
    if (data_done) begin
      done_cyc_q.push_back(cyc);
      done_val_q.push_back(data_out);
    end
    if (!enc_dec) dec_cnt++;
  end

  // ---------------- checking ------------------------------------------------
  task automatic check_val(input string tag, input logic [S-1:0] got, input logic [S-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // One data job with no competing key traffic: done 6 cycles after grant.
  task automatic run_job(input string tag, input logic [S-1:0] st, input logic mode,
                         input logic [S-1:0] exp);
    int t, nd, d0;
    @(negedge clk);
    data_req = 1'b1; data_state = st; data_enc_dec = mode;
    #1;
    check_val({tag, "_gnt"}, S'(data_gnt), S'(1));
    t = cyc; nd = done_cyc_q.size(); d0 = dec_cnt;
    @(negedge clk);
    data_req = 1'b0;
    wait_cyc(7);
    check_val({tag, "_ndone"}, S'(done_cyc_q.size() - nd), S'(1));
    if (done_cyc_q.size() > nd) begin
      check_val({tag, "_lat"}, S'(done_cyc_q[nd] - t), S'(6));
      check_val({tag, "_out_at_done"}, done_val_q[nd], exp);
    end
    check_val({tag, "_out_hold"}, data_out, exp);
    check_val({tag, "_dec_cycles"}, S'(dec_cnt - d0), mode ? S'(0) : S'(4));
  endtask

  // ---------------- stimulus ------------------------------------------------
  initial begin
    int t, tk, td, t2, kg, nk, nd;
    logic [S-1:0] mix, mix_exp;

    rst = 1'b1; key_req = 1'b0; key_word = '0;
    data_req = 1'b0; data_enc_dec = 1'b0; data_state = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_pulses", S'({key_gnt, data_gnt, key_rsp_valid, data_done}), S'(4'b0000));
    check_val("rst_key_rsp", S'(key_rsp), S'(0));
    check_val("rst_data_out", data_out, S'(0));
    check_val("rst_enc_dec", S'(enc_dec), S'(1));
    check_val("rst_sbox_in", S'(sbox_in), S'(0));
    @(negedge clk);
    rst = 1'b0;

    // Key only
    @(negedge clk);
    key_req = 1'b1; key_word = 32'h0000_0000;
    #1;
    check_val("key_gnt", S'(key_gnt), S'(1));
    check_val("key_enc_dec", S'(enc_dec), S'(1));
    tk = cyc; nk = key_cyc_q.size();
    @(negedge clk);
    key_req = 1'b0;
    wait_cyc(3);
    check_val("key_nrsp", S'(key_cyc_q.size() - nk), S'(1));
    if (key_cyc_q.size() > nk) begin
      check_val("key_lat", S'(key_cyc_q[nk] - tk), S'(2));
      check_val("key_rsp", S'(key_val_q[nk]), S'(32'h6363_6363));
    end
    check_val("key_rsp_hold", S'(key_rsp), S'(32'h6363_6363));

    // Back-to-back keys
    @(negedge clk);
    key_req = 1'b1; key_word = 32'h0000_0000;
    #1;
    check_val("kk_gnt0", S'(key_gnt), S'(1));
    tk = cyc; nk = key_cyc_q.size();
    @(negedge clk);
    key_word = 32'h5353_5353;
    #1;
    check_val("kk_gnt1", S'(key_gnt), S'(1));
    @(negedge clk);
    key_req = 1'b0;
    wait_cyc(3);
    check_val("kk_nrsp", S'(key_cyc_q.size() - nk), S'(2));
    if (key_cyc_q.size() > nk + 1) begin
      check_val("kk_lat0", S'(key_cyc_q[nk] - tk), S'(2));
      check_val("kk_lat1", S'(key_cyc_q[nk+1] - tk), S'(3));
      check_val("kk_rsp0", S'(key_val_q[nk]), S'(32'h6363_6363));
      check_val("kk_rsp1", S'(key_val_q[nk+1]), S'(32'hEDED_EDED));
    end

    // Encrypt / decrypt / mixed-word jobs
    run_job("enc", {16{8'h53}}, 1'b1, {16{8'hED}});
    run_job("dec", {16{8'h63}}, 1'b0, {16{8'h00}});
    mix = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    for (int i = 0; i < DATA_WORDS; i++) mix_exp[W*i +: W] = fwd_w(mix[W*i +: W]);
    run_job("mix_enc", mix, 1'b1, mix_exp);
    for (int i = 0; i < DATA_WORDS; i++) mix_exp[W*i +: W] = inv_w(mix[W*i +: W]);
    run_job("mix_dec", mix, 1'b0, mix_exp);

    // Simultaneous key and data requests in IDLE
    @(negedge clk);
    key_req = 1'b1; key_word = 32'h5353_5353;
    data_req = 1'b1; data_state = {16{8'h00}}; data_enc_dec = 1'b1;
    #1;
    check_val("sim_key_gnt", S'({key_gnt, data_gnt}), S'(2'b10));
    tk = cyc; nk = key_cyc_q.size(); nd = done_cyc_q.size();
    @(negedge clk);
    key_req = 1'b0;
    #1;
    check_val("sim_data_gnt", S'(data_gnt), S'(1));
    td = cyc;
    @(negedge clk);
    data_req = 1'b0;
    wait_cyc(7);
    check_val("sim_counts", S'({key_cyc_q.size() - nk, done_cyc_q.size() - nd}), S'({32'd1, 32'd1}));
    if (key_cyc_q.size() > nk && done_cyc_q.size() > nd) begin
      check_val("sim_key", S'({key_cyc_q[nk] - tk, key_val_q[nk]}), S'({32'd2, 32'hEDED_EDED}));
      check_val("sim_done_lat", S'(done_cyc_q[nd] - td), S'(6));
    end
    check_val("sim_data_out", data_out, {16{8'h63}});

    // Key request arriving during a job
    @(negedge clk);
    data_req = 1'b1; data_state = {16{8'h00}}; data_enc_dec = 1'b1;
    #1;
    check_val("kd_gnt", S'(data_gnt), S'(1));
    t = cyc; nk = key_cyc_q.size(); nd = done_cyc_q.size();
    @(negedge clk);
    data_req = 1'b0;
    @(negedge clk);
    key_req = 1'b1; key_word = 32'h5353_5353;
    #1;
    kg = -1;
    for (int i = 0; i < 8; i++) begin
      if (key_gnt) begin
        kg = cyc;
        break;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    key_req = 1'b0;
    wait_cyc(8);
`ifdef SBOX_SCHED_KEY_PREEMPT_EN
    check_val("kd_key_gnt_cyc", S'(kg - t), S'(2));
`else
    check_val("kd_key_gnt_cyc", S'(kg - t), S'(5));
`endif
    check_val("kd_counts", S'({key_cyc_q.size() - nk, done_cyc_q.size() - nd}), S'({32'd1, 32'd1}));
    if (key_cyc_q.size() > nk && done_cyc_q.size() > nd) begin
      check_val("kd_key", S'({key_cyc_q[nk] - kg, key_val_q[nk]}), S'({32'd2, 32'hEDED_EDED}));
`ifdef SBOX_SCHED_KEY_PREEMPT_EN
      check_val("kd_done_lat", S'(done_cyc_q[nd] - t), S'(7));
`else
      check_val("kd_done_lat", S'(done_cyc_q[nd] - t), S'(6));
`endif
    end
    check_val("kd_data_out", data_out, {16{8'h63}});

    // Back-to-back data jobs: second grant in the cycle after the last issue
    @(negedge clk);
    data_req = 1'b1; data_state = {16{8'h53}}; data_enc_dec = 1'b1;
    #1;
    check_val("bb_gnt0", S'(data_gnt), S'(1));
    t = cyc; nd = done_cyc_q.size();
    @(negedge clk);
    data_state = {16{8'h00}};
    #1;
    t2 = -1;
    for (int i = 0; i < 8; i++) begin
      if (data_gnt) begin
        t2 = cyc;
        break;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    data_req = 1'b0;
    wait_cyc(8);
    check_val("bb_gnt1_cyc", S'(t2 - t), S'(5));
    check_val("bb_ndone", S'(done_cyc_q.size() - nd), S'(2));
    if (done_cyc_q.size() > nd + 1) begin
      check_val("bb_done0", S'({done_cyc_q[nd] - t, done_cyc_q[nd+1] - t}), S'({32'd6, 32'd11}));
      check_val("bb_out0", done_val_q[nd], {16{8'hED}});
      check_val("bb_out1", done_val_q[nd+1], {16{8'h63}});
    end

    // Reset mid-job after two issues
    @(negedge clk);
    data_req = 1'b1; data_state = {16{8'h53}}; data_enc_dec = 1'b1;
    #1;
    check_val("rj_gnt", S'(data_gnt), S'(1));
    nd = done_cyc_q.size(); nk = key_cyc_q.size();
    @(negedge clk);
    data_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rj_outs", S'({data_out, key_rsp}), S'(0));
    check_val("rj_flags", S'({key_rsp_valid, data_done, enc_dec}), S'(3'b001));
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(8);
    check_val("rj_no_done", S'({done_cyc_q.size() - nd, key_cyc_q.size() - nk}), S'(0));
    check_val("rj_out_zero", data_out, S'(0));
    run_job("post_rst", {16{8'h00}}, 1'b1, {16{8'h63}});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "timeout");
  end

endmodule : tb_sbox_sched

// File: doc/sbox_sched.md
Name: sbox_sched

Overview:
- Scheduler sharing one registered S-box bank (SBOX_NUM byte lanes, 1-cycle latency) between two requesters: key expansion (one word per request) and round datapath (full state, DATA_WORDS words).
- Sequences the state through the bank word by word, tags each issue, and routes returning bytes back to the correct requester.
- Sits between the key-expansion unit, the round datapath, and the S-box bank instance.

Parameters:
- SBOX_NUM, 4, byte lanes in the bank; word width W = 8*SBOX_NUM.
- DATA_WORDS, 4, words per datapath job; state width S = W*DATA_WORDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- key_req  in  1  key-expansion request; held until key_gnt.
- key_word  in  W  bytes to substitute; held stable while key_req is high.
- key_gnt  out  1  combinational pulse in the cycle key_word is issued to the bank.
- key_rsp_valid  out  1  registered one-cycle pulse.
- key_rsp  out  W  substituted word (forward S-box); holds its value until the next response.
- data_req  in  1  datapath job request.
- data_enc_dec  in  1  job mode, sampled with data_state; 1 = encrypt (forward), 0 = decrypt (inverse).
- data_state  in  S  job input; word i = bits [W*i+W-1 : W*i].
- data_gnt  out  1  combinational pulse; data_state and data_enc_dec are sampled this cycle.
- data_done  out  1  registered one-cycle pulse.
- data_out  out  S  job result; stable from data_done until the next job's first capture.
- sbox_in  out  W  to bank.
- enc_dec  out  1  to bank; job mode during data issues, forced to 1 during key issues and in IDLE.
- sbox_out_enc  in  W  from bank.
- sbox_out_dec  in  W  from bank.

Behaviour:
- Reset values:
  - All outputs 0, except enc_dec = 1.
  - FSM = IDLE.
  - Issue tag invalid.
  - Job buffer and counter cleared.
- Reset mid-job aborts the job: no data_done, no key_rsp_valid. Any in-flight bank result is discarded.
- FSM states: IDLE, DATA.
- IDLE arbitration:
  - key_req has priority over data_req.
  - key_req=1: key_gnt=1, sbox_in=key_word, tag={valid, KEY}.
  - Else data_req=1: data_gnt=1, latch data_state and data_enc_dec, cnt=0, go to DATA.
- DATA, one issue per cycle:
  - sbox_in = latched word[cnt], tag = {valid, DATA, cnt}, cnt increments.
  - After issuing word DATA_WORDS-1, return to IDLE.
  - data_req is ignored while in DATA (no data_gnt).
- Tag pipeline:
  - The tag registers on the issue edge.
  - The next cycle, the bank output is captured per tag.
  - KEY tag: key_rsp <= sbox_out_enc, key_rsp_valid pulses in the following cycle.
  - DATA tag: data_out word[idx] <= sbox_out_enc or sbox_out_dec, per latched mode.
- data_done pulses the cycle after the last word is captured.
- Timing, no preemption:
  - Data gnt in cycle T: issues T+1..T+1+DATA_WORDS-1, data_done at T+DATA_WORDS+2 (T+6 for defaults).
  - Key gnt in cycle K: key_rsp_valid at K+2.
- Back-to-back:
  - A new key request may be granted every cycle; responses stream at one per cycle.
  - A new data job may be granted in the cycle after the last data issue (that cycle is IDLE).
- No cycle is ever lost: the bank receives at most one issue per cycle, always tagged.

Optional Feature:
- Macro: SBOX_SCHED_KEY_PREEMPT_EN.
- Defined:
  - In DATA, key_req=1 steals the issue slot: key_gnt=1 and a KEY tag is issued.
  - cnt holds and enc_dec is forced to 1 that cycle.
  - The data job resumes the next cycle; data_done is delayed by one cycle per stolen slot.
- Undefined:
  - key_req waits in DATA until IDLE; worst-case key wait is DATA_WORDS cycles.

Decomposition:
- Shared package/include sbox_sched_pkg holds:
  - FSM state encodings (IDLE, DATA);
  - tag type constants (TAG_KEY, TAG_DATA);
  - mode constant MODE_ENC = 1.
- No sub-module; the existing S-box bank is instantiated beside this block at the parent level.

Test Plan:
- Key only: key_word=0x00000000 -> key_gnt same cycle, key_rsp_valid 2 cycles later, key_rsp=0x63636363.
- Encrypt job: data_state all bytes 0x53, enc -> data_gnt, data_done 6 cycles later, data_out all 0xED.
- Decrypt job: all bytes 0x63, data_enc_dec=0 -> data_out all 0x00; enc_dec=0 during the 4 issue cycles.
- Simultaneous key_req and data_req in IDLE -> key granted first, data granted next cycle, both results correct.
- key_req asserted during a job:
  - Macro undefined: key granted only after the 4th issue, job done at T+6.
  - Macro defined: key granted immediately, data_done at T+7, both results correct.
- rst pulsed mid-job after 2 issues -> no data_done, outputs zero; a fresh job afterwards completes normally.
